// File: rtl/display_timings.sv
// 640x480@60 raster timing generator (800x525 total) on clk_pix.
// Optional frame counter output enabled by defining DISPLAY_FRAME_CNT_EN.
module display_timings #(
    parameter int   H_RES  = 640,
    parameter int   H_FP   = 16,
    parameter int   H_SYNC = 96,
    parameter int   H_BP   = 48,
    parameter int   V_RES  = 480,
    parameter int   V_FP   = 10,
    parameter int   V_SYNC = 2,
    parameter int   V_BP   = 33,
    parameter logic H_POL  = 1'b0,
    parameter logic V_POL  = 1'b0
) (
    input  logic        clk_pix,
    input  logic        sim_rst,
    output logic [9:0]  sx,
    output logic [9:0]  sy,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame,
    output logic        line
`ifdef DISPLAY_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_RES);
    localparam logic [9:0] V_ACT  = 10'(V_RES);
    localparam logic [9:0] H_SS   = 10'(H_RES + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_RES + H_FP + H_SYNC);
    localparam logic [9:0] V_SS   = 10'(V_RES + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_RES + V_FP + V_SYNC);

    logic [9:0] sx_r;
    logic [9:0] sy_r;
    logic       de_r;
    logic       hsync_r;
    logic       vsync_r;
    logic       frame_r;
    logic       line_r;

    logic [9:0] sx_next_s;
    logic [9:0] sy_next_s;
    logic       de_next_s;
    logic       hsync_next_s;
    logic       vsync_next_s;
    logic       frame_next_s;
    logic       line_next_s;

    // Next raster position: sx wraps at end of line, sy advances only on that wrap
    always_comb begin
        sx_next_s = sx_r + 10'd1;
        sy_next_s = sy_r;
        if (sx_r == H_LAST) begin
            sx_next_s = 10'd0;
            if (sy_r == V_LAST) begin
                sy_next_s = 10'd0;
            end else begin
                sy_next_s = sy_r + 10'd1;
            end
        end else begin
            sx_next_s = sx_r + 10'd1;
        end
    end

    // Decode from the next position so registered flags line up with sx/sy
    always_comb begin
        de_next_s    = (sx_next_s < H_ACT) && (sy_next_s < V_ACT);
        line_next_s  = (sx_next_s == 10'd0);
        frame_next_s = (sx_next_s == 10'd0) && (sy_next_s == 10'd0);
        if ((sx_next_s >= H_SS) && (sx_next_s < H_SE)) begin
            hsync_next_s = H_POL;
        end else begin
            hsync_next_s = ~H_POL;
        end
        if ((sy_next_s >= V_SS) && (sy_next_s < V_SE)) begin
            vsync_next_s = V_POL;
        end else begin
            vsync_next_s = ~V_POL;
        end
    end

    // Position and timing flag registers; reset parks at the last pixel of the frame
    always_ff @(posedge clk_pix) begin
        if (sim_rst) begin
            sx_r    <= H_LAST;
            sy_r    <= V_LAST;
            de_r    <= 1'b0;
            hsync_r <= ~H_POL;
            vsync_r <= ~V_POL;
            frame_r <= 1'b0;
            line_r  <= 1'b0;
        end else begin
            sx_r    <= sx_next_s;
            sy_r    <= sy_next_s;
            de_r    <= de_next_s;
            hsync_r <= hsync_next_s;
            vsync_r <= vsync_next_s;
            frame_r <= frame_next_s;
            line_r  <= line_next_s;
        end
    end

    assign sx    = sx_r;
    assign sy    = sy_r;
    assign de    = de_r;
    assign hsync = hsync_r;
    assign vsync = vsync_r;
    assign frame = frame_r;
    assign line  = line_r;

`ifdef DISPLAY_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Frame counter steps together with the frame strobe, so frame 1 reads 1
    always_ff @(posedge clk_pix) begin
        if (sim_rst) begin
            frame_cnt_r <= 16'd0;
        end else if (frame_next_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`endif

endmodule
